register_scoreboard: RTL
========================

REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have port: regwrite_cur  input  1  instruction leaving ID this cycle writes a register (already gated by en_idex/!flush_idex).
REQ-004 SHALL have port: regwrite_adr_cur  input  3  destination register of that instruction.
REQ-005 SHALL have port: from_main_mem_cur  input  1  that instruction is a load (data available only at WB).
REQ-006 SHALL have port: en_idex, en_exmem, en_memwb  input  1 each  stage-register enables.
REQ-007 SHALL have port: flush_idex, flush_exmem, flush_memwb  input  1 each  stage-register flushes.
REQ-008 SHALL have port: register_invalid  output  3 x [7:0]  per-register hazard code for the instruction in ID.
REQ-009 SHALL have port: stall_count  output  16  count of cycles in which any register reports code 1.

Function
REQ-010 SHALL track three in-flight producer slots EX, MEM, WB, each {valid, adr[2:0], load}.
REQ-011 SHALL, on clk edge with en_idex=1, load EX with {regwrite_cur & !flush_idex, regwrite_adr_cur, from_main_mem_cur}; en_idex=0 holds EX.
REQ-012 SHALL, with en_exmem=1, load MEM from EX, forcing valid=0 when flush_exmem=1; en_exmem=0 holds MEM.
REQ-013 SHALL, with en_memwb=1, load WB from MEM, forcing valid=0 when flush_memwb=1; en_memwb=0 holds WB.
REQ-014 SHALL compute register_invalid[r] combinationally from slots only (zero-cycle latency), using the youngest valid slot whose adr==r (priority EX > MEM > WB).
REQ-015 SHALL encode: no match -> 0; youngest in EX -> 1; youngest in MEM and load -> 1; youngest in MEM and not load -> 2 (forward from EX/MEM); youngest in WB -> 3 (forward from WB).
REQ-016 SHALL report distinct codes for distinct registers in the same cycle; one slot never affects a register other than its adr.
REQ-017 SHALL, when EX, MEM and WB all target the same r, report 1 (youngest wins).
REQ-018 SHALL increment stall_count on every edge where any register_invalid[r]==1, saturating at 16'hFFFF.
REQ-019 SHALL, on simultaneous flush and enable of a stage, apply flush (valid=0) regardless of incoming valid.

Reset
REQ-020 SHALL, while reset=1, immediately clear all slot valid bits and stall_count to 0 independent of clk.
REQ-021 SHALL drive register_invalid[r]=0 for all r and stall_count=0 while and after reset until new producers enter.
REQ-022 SHALL, on reset asserted mid-operation, discard all in-flight producers with no residual codes.

Configuration
REQ-023 SHALL honour macro SCOREBOARD_FWD_EN: defined -> codes per REQ-015; undefined -> any matching valid slot (EX, MEM or WB) reports 1 and codes 2/3 never appear.
REQ-024 SHALL keep slot tracking, reset and stall_count behaviour identical in both configurations.

Verification
REQ-025 SHALL cover: ADD to r3 enters (regwrite_cur=1, adr=3, load=0), all en=1 -> r3 codes 1,2,3,0 on the four following cycles; other registers 0.
REQ-026 SHALL cover: load to r5 enters -> r5 codes 1,1,3,0; stall_count increments by 2.
REQ-027 SHALL cover: writes to r2 on two consecutive cycles -> r2 shows 1, then 1 (younger in EX), then 2, then 3, then 0.
REQ-028 SHALL cover: r4 producer in EX, flush_exmem=1 at next edge -> r4 reports 0 next cycle.
REQ-029 SHALL cover: r1 producer in MEM, en_exmem=en_memwb=0 for 3 cycles -> r1 holds code 2; then en=1 -> 3, then 0.
REQ-030 SHALL cover: reset pulsed between edges with r6 in EX and r7 in WB -> all codes 0 and stall_count=0 immediately; SCOREBOARD_FWD_EN undefined rerun of REQ-025 -> r3 codes 1,1,1,0.

Source files
------------

// File: rtl/register_scoreboard.sv
// Register hazard scoreboard: tracks EX/MEM/WB producers and reports per-register hazard codes.
// Macro SCOREBOARD_FWD_EN enables forwarding codes 2/3; when undefined every match reports a stall.
module register_scoreboard (
   input  logic                clk,
   input  logic                reset,
   input  logic                regwrite_cur,
   input  logic [2:0]          regwrite_adr_cur,
   input  logic                from_main_mem_cur,
   input  logic                en_idex,
   input  logic                en_exmem,
   input  logic                en_memwb,
   input  logic                flush_idex,
   input  logic                flush_exmem,
   input  logic                flush_memwb,
   output logic [7:0][2:0]     register_invalid,
   output logic [15:0]         stall_count
);

   localparam int unsigned ADR_W    = 3;
   localparam int unsigned NUM_REGS = 8;
   localparam int unsigned CODE_W   = 3;
   localparam int unsigned CNT_W    = 16;

   localparam logic [CODE_W-1:0] CODE_NONE   = CODE_W'(0);
   localparam logic [CODE_W-1:0] CODE_STALL  = CODE_W'(1);
   localparam logic [CODE_W-1:0] CODE_FWD_MEM = CODE_W'(2);
   localparam logic [CODE_W-1:0] CODE_FWD_WB  = CODE_W'(3);
   localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

`ifdef SCOREBOARD_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   typedef struct packed {
      logic             valid;
      logic [ADR_W-1:0] adr;
      logic             load;
   } slot_t;

   slot_t ex_slot, mem_slot, wb_slot;
   logic  any_stall_c;

   // Producer slots advance with their stage enables; a flush always wins over incoming valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_slot  <= '0;
         mem_slot <= '0;
         wb_slot  <= '0;
      end else begin
         if (en_idex) begin
            ex_slot.valid <= regwrite_cur & ~flush_idex;
            ex_slot.adr   <= regwrite_adr_cur;
            ex_slot.load  <= from_main_mem_cur;
         end
         if (en_exmem) begin
            mem_slot       <= ex_slot;
            mem_slot.valid <= ex_slot.valid & ~flush_exmem;
         end
         if (en_memwb) begin
            wb_slot       <= mem_slot;
            wb_slot.valid <= mem_slot.valid & ~flush_memwb;
         end
      end
   end

   // Youngest matching producer decides each register's code.
   always_comb begin
      register_invalid = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         register_invalid[r] = CODE_NONE;
         if (ex_slot.valid && ex_slot.adr == ADR_W'(r)) begin
            register_invalid[r] = CODE_STALL;
         end else if (mem_slot.valid && mem_slot.adr == ADR_W'(r)) begin
            register_invalid[r] = (FWD_EN && !mem_slot.load) ? CODE_FWD_MEM : CODE_STALL;
         end else if (wb_slot.valid && wb_slot.adr == ADR_W'(r)) begin
            register_invalid[r] = FWD_EN ? CODE_FWD_WB : CODE_STALL;
         end
      end
   end

   always_comb begin
      any_stall_c = 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         if (register_invalid[r] == CODE_STALL) any_stall_c = 1'b1;
      end
   end

   // Saturating count of cycles in which ID had to stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
      end else if (any_stall_c && stall_count != CNT_MAX) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule
